mod_reduce: RTL and testbench

//  Sequential modular reducer: computes result_out = product_in mod modulus_in.

---
 rtl/mod_reduce.sv | 136 +++++++++++++
 tb/tb_mod_reduce.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce.sv
// mod_reduce
//   Sequential modular reducer: result_out = product_in mod modulus_in.
//   Restoring shift-subtract, MSB first, one product bit per clock, so a
//   reduction takes PRODUCT_SIZE cycles from the acceptance edge to valid_out.
//
// Optional feature (macro MODRED_ZERO_MOD_CHECK_EN):
//   adds err_out. A request with modulus_in == 0 is rejected in IDLE:
//   result_out <= 0, err_out <= 1, and valid_out pulses on the next cycle.
//   Without the macro, N = 0 runs the normal flow and yields product_in[MOD_SIZE-1:0].
//
// Ports
//   clk_in      in   1             clock, posedge
//   rst_in      in   1             asynchronous active-low reset
//   product_in  in   PRODUCT_SIZE  dividend, sampled on the acceptance edge
//   modulus_in  in   MOD_SIZE      modulus N, sampled on the acceptance edge
//   valid_in    in   1             start request (ignored while busy)
//   result_out  out  MOD_SIZE      residue, held until the next completion
//   busy_out    out  1             high from the cycle after acceptance until completion
//   valid_out   out  1             one-cycle pulse when result_out updates
//   err_out     out  1             zero-modulus flag (macro builds only)
module mod_reduce #(
   parameter int unsigned MOD_SIZE     = 1024,
   parameter int unsigned PRODUCT_SIZE = 2 * MOD_SIZE
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [PRODUCT_SIZE-1:0] product_in,
   input  logic [MOD_SIZE-1:0]     modulus_in,
   input  logic                    valid_in,
   output logic [MOD_SIZE-1:0]     result_out,
   output logic                    busy_out,
`ifdef MODRED_ZERO_MOD_CHECK_EN
   output logic                    valid_out,
   output logic                    err_out
`else
   output logic                    valid_out
`endif
);

   localparam int unsigned CNT_W = $clog2(PRODUCT_SIZE);

   typedef enum logic {IDLE, REDUCE} state_t;

   state_t                  state_q;
   logic [PRODUCT_SIZE-1:0] p_q;
   logic [MOD_SIZE-1:0]     n_q;
   logic [MOD_SIZE-1:0]     r_q;
   logic [MOD_SIZE-1:0]     r_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [MOD_SIZE-1:0]     result_q;
   logic                    busy_q;
   logic                    valid_q;
`ifdef MODRED_ZERO_MOD_CHECK_EN
   logic                    err_q;
`endif

   // One restoring step. T is MOD_SIZE+1 bits so the compare is exact even
   // for N = 2**MOD_SIZE-1; since R < N implies T < 2N, the low MOD_SIZE bits
   // of T-N are the full remainder and the carry bit is not needed.
   logic [MOD_SIZE:0]   t;
   logic [MOD_SIZE-1:0] diff;
   logic                ge;

   always_comb begin
      t    = {r_q, p_q[cnt_q]};
      ge   = (t >= {1'b0, n_q});
      diff = t[MOD_SIZE-1:0] - n_q;
      r_d  = ge ? diff : t[MOD_SIZE-1:0];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= IDLE;
         p_q      <= '0;
         n_q      <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
`ifdef MODRED_ZERO_MOD_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               if (valid_in) begin
`ifdef MODRED_ZERO_MOD_CHECK_EN
                  if (modulus_in == '0) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                     valid_q  <= 1'b1;
                  end else begin
                     err_q    <= 1'b0;
                     p_q      <= product_in;
                     n_q      <= modulus_in;
                     r_q      <= '0;
                     cnt_q    <= CNT_W'(PRODUCT_SIZE - 1);
                     busy_q   <= 1'b1;
                     state_q  <= REDUCE;
                  end
`else
                  p_q     <= product_in;
                  n_q     <= modulus_in;
                  r_q     <= '0;
                  cnt_q   <= CNT_W'(PRODUCT_SIZE - 1);
                  busy_q  <= 1'b1;
                  state_q <= REDUCE;
`endif
               end
            end
            REDUCE: begin
               r_q <= r_d;
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  result_q <= r_d;
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result_out = result_q;
   assign busy_out   = busy_q;
   assign valid_out  = valid_q;
`ifdef MODRED_ZERO_MOD_CHECK_EN
   assign err_out    = err_q;
`endif

endmodule

// File: tb/tb_mod_reduce.sv
// tb_mod_reduce
//   Scoreboard bench for mod_reduce at MOD_SIZE=8, PRODUCT_SIZE=16.
//   Stimulus pushes the reference residue (computed with the % operator)
//   and acceptance cycle; an independent monitor pops on every valid_out.
module tb_mod_reduce;

   localparam int unsigned MS  = 8;
   localparam int unsigned PS  = 16;
   localparam int unsigned LAT = PS;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic [PS-1:0] product_in;
   logic [MS-1:0] modulus_in;
   logic          valid_in;
   logic [MS-1:0] result_out;
   logic          busy_out;
   logic          valid_out;
`ifdef MODRED_ZERO_MOD_CHECK_EN
   logic          err_out;
`endif

   mod_reduce #(.MOD_SIZE(MS), .PRODUCT_SIZE(PS)) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .product_in (product_in),
      .modulus_in (modulus_in),
      .valid_in   (valid_in),
      .result_out (result_out),
      .busy_out   (busy_out),
`ifdef MODRED_ZERO_MOD_CHECK_EN
      .valid_out  (valid_out),
      .err_out    (err_out)
`else
      .valid_out  (valid_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [MS-1:0] res;
      logic          err;
      int unsigned   acc;
      int unsigned   lat;
   } exp_t;

   exp_t          sb[$];
   int unsigned   cyc = 0;
   int            checks = 0;
   int            errors = 0;
   logic [MS-1:0] last_res = '0;

   always @(posedge clk_in) cyc++;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [MS-1:0] ref_mod(input longint unsigned p, input longint unsigned n);
      if (n == 0) return MS'(p % (longint'(1) << MS));
      return MS'(p % n);
   endfunction

   // Monitor
   always @(negedge clk_in) begin
      if (rst_in) begin
         if (valid_out) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", valid_out, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", result_out, e.res);
               chk("latency", cyc - e.acc, e.lat);
`ifdef MODRED_ZERO_MOD_CHECK_EN
               chk("err", err_out, e.err);
`endif
               last_res = e.res;
            end
         end else begin
            chk("hold", result_out, last_res);
         end
      end
   end

   // Issue one request; returns #1 after the completion edge, so a following
   // call is accepted in the same cycle valid_out is high.
   task automatic op(input logic [PS-1:0] p, input logic [MS-1:0] n, input bit noise);
      exp_t e;
      product_in = p;
      modulus_in = n;
      valid_in   = 1'b1;
      @(posedge clk_in); #1;
      valid_in   = 1'b0;
      product_in = PS'($urandom);
      modulus_in = MS'($urandom);
      e.res = ref_mod(p, n);
      e.err = 1'b0;
      e.acc = cyc;
      e.lat = LAT;
`ifdef MODRED_ZERO_MOD_CHECK_EN
      if (n == 0) begin
         e.res = '0;
         e.err = 1'b1;
         e.lat = 0;
         sb.push_back(e);
         chk("busy_zero_mod", busy_out, 0);
         return;
      end
`endif
      sb.push_back(e);
      for (int i = 0; i < int'(LAT); i++) begin
         chk("busy_high", busy_out, 1);
         valid_in = noise && ($urandom_range(0, 1) == 1);
         if (valid_in) begin
            product_in = PS'($urandom);
            modulus_in = MS'($urandom);
         end
         @(posedge clk_in); #1;
      end
      valid_in = 1'b0;
      chk("busy_low_at_done", busy_out, 0);
      chk("valid_at_done", valid_out, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   initial begin
      rst_in     = 1'b0;
      valid_in   = 1'b0;
      product_in = '0;
      modulus_in = '0;
      idle(3);
      chk("rst_result", result_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_valid", valid_out, 0);
`ifdef MODRED_ZERO_MOD_CHECK_EN
      chk("rst_err", err_out, 0);
`endif
      rst_in = 1'b1;
      idle(2);

      // Directed cases, issued back-to-back
      op(16'hFFFF, 8'd251, 1'b0);
      op(16'd1000, 8'd7, 1'b0);
      op(16'd5, 8'd13, 1'b0);
      op(16'h1234, 8'd1, 1'b0);
      op(16'h0000, 8'd200, 1'b0);
      op(16'hFFFF, 8'd255, 1'b0);
      op(16'hFEFF, 8'd255, 1'b0);
      op(16'h00FE, 8'd255, 1'b0);
      idle(3);

      // valid_in pulses while busy must be ignored
      op(16'hABCD, 8'd97, 1'b1);
      op(16'h7FFF, 8'd128, 1'b1);
      idle(2);

      // Reset in the middle of REDUCE abandons the operation
      product_in = 16'hFFFF;
      modulus_in = 8'd3;
      valid_in   = 1'b1;
      @(posedge clk_in); #1;
      valid_in = 1'b0;
      idle(7);
      rst_in = 1'b0;
      sb.delete();
      last_res = '0;
      #1;
      chk("midrst_result", result_out, 0);
      chk("midrst_busy", busy_out, 0);
      chk("midrst_valid", valid_out, 0);
`ifdef MODRED_ZERO_MOD_CHECK_EN
      chk("midrst_err", err_out, 0);
`endif
      idle(2);
      rst_in = 1'b1;
      idle(20);
      op(16'hFFFF, 8'd251, 1'b0);
      idle(1);

      // Zero modulus
      op(16'h1234, 8'd0, 1'b0);
      idle(1);
      op(16'h1234, 8'd10, 1'b0);
      idle(1);

      // Randomized requests with boundary moduli mixed in
      for (int k = 0; k < 300; k++) begin
         logic [MS-1:0] n;
         logic [PS-1:0] p;
         case ($urandom_range(0, 5))
            0:       n = 8'd1;
            1:       n = 8'd255;
            default: n = MS'($urandom_range(1, 255));
         endcase
         p = ($urandom_range(0, 7) == 0) ? PS'($urandom_range(0, 300)) : PS'($urandom);
         op(p, n, ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end

      idle(4);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
